// File: rtl/dircc_send_packet_queue.sv
// Packet queue between the per-application send handler and the router link:
// buffers whole packets and serialises them LSB flit first over valid/ready.
module dircc_send_packet_queue #(
  parameter int unsigned PACKET_WIDTH = 96,
  parameter int unsigned FLIT_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PACKET_WIDTH-1:0] packet_in,
  input  logic                    packet_in_valid,
  output logic                    packet_in_ready,
  output logic [FLIT_WIDTH-1:0]   flit_out,
  output logic                    flit_out_valid,
  input  logic                    flit_out_ready,
  output logic                    flit_out_sop,
  output logic                    flit_out_eop,
  output logic [LW-1:0]           fifo_level,
  output logic [15:0]             drop_count
);

  localparam int unsigned FLITS = PACKET_WIDTH / FLIT_WIDTH;
  localparam int unsigned FIW   = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int unsigned PTRW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef logic [FLITS-1:0][FLIT_WIDTH-1:0] pkt_t;

  pkt_t            mem_q [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [FIW-1:0]  fidx_q, fidx_d;
  logic [15:0]     drop_q, drop_d;

  logic full_c, valid_c, eop_c, xfer_c, push_c, pop_c, drop_c;

  // Next-state: fullness is taken from the level before the edge, so a push
  // landing on the same edge as a pop from a full queue is still dropped.
  always_comb begin
    full_c   = (level_q == LW'(FIFO_DEPTH));
    valid_c  = (level_q != '0);
    eop_c    = (fidx_q == FIW'(FLITS - 1));
    xfer_c   = valid_c && flit_out_ready;
    pop_c    = xfer_c && eop_c;
    push_c   = packet_in_valid && !full_c;
    drop_c   = packet_in_valid && full_c;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    fidx_d   = fidx_q;
    drop_d   = drop_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTRW'(1);
    if (xfer_c) fidx_d = eop_c ? '0 : fidx_q + FIW'(1);

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop_c && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      fidx_q   <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      fidx_q   <= fidx_d;
      drop_q   <= drop_d;
    end
  end

  // Packet storage carries no reset; stale entries are masked by the level.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= pkt_t'(packet_in);
  end

  // Outputs decode registered state only, so they are stable until a transfer.
  always_comb begin
    flit_out_valid  = valid_c;
    flit_out        = mem_q[rd_ptr_q][fidx_q];
    flit_out_sop    = valid_c && (fidx_q == '0);
    flit_out_eop    = valid_c && eop_c;
    packet_in_ready = !full_c;
    fifo_level      = level_q;
    drop_count      = drop_q;
  end

endmodule

// File: tb/tb_dircc_send_packet_queue.sv
// Self-checking bench for dircc_send_packet_queue: directed scenarios plus a
// randomized stream compared against a packet-queue reference model.
module tb_dircc_send_packet_queue;

  localparam int unsigned PW = 96;
  localparam int unsigned FW = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned F  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [PW-1:0] packet_in;
  logic          packet_in_valid;
  logic          packet_in_ready;
  logic [FW-1:0] flit_out;
  logic          flit_out_valid;
  logic          flit_out_ready;
  logic          flit_out_sop;
  logic          flit_out_eop;
  logic [2:0]    fifo_level;
  logic [15:0]   drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of whole packets, flit index into the head, drops.
  logic [PW-1:0] mq[$];
  int            mfidx;
  int            mdrop;

  dircc_send_packet_queue #(.PACKET_WIDTH(PW), .FLIT_WIDTH(FW), .FIFO_DEPTH(D)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .packet_in       (packet_in),
    .packet_in_valid (packet_in_valid),
    .packet_in_ready (packet_in_ready),
    .flit_out        (flit_out),
    .flit_out_valid  (flit_out_valid),
    .flit_out_ready  (flit_out_ready),
    .flit_out_sop    (flit_out_sop),
    .flit_out_eop    (flit_out_eop),
    .fifo_level      (fifo_level),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] slice(input logic [PW-1:0] p, input int k);
    return p[k*FW +: FW];
  endfunction

  function automatic logic [FW-1:0] model_flit();
    logic [PW-1:0] h;
    if (mq.size() == 0) return '0;
    h = mq[0];
    return slice(h, mfidx);
  endfunction

  function automatic logic [PW-1:0] rnd_pkt();
    return {$urandom, $urandom, $urandom};
  endfunction

  // One clock: drive at negedge, advance the model on the edge, return at negedge.
  task automatic cycle(input logic v, input logic [PW-1:0] p, input logic r);
    bit full;
    packet_in_valid = v;
    packet_in       = p;
    flit_out_ready  = r;
    @(posedge clk);
    full = (mq.size() == D);
    if (mq.size() > 0 && r) begin
      if (mfidx == F - 1) begin
        void'(mq.pop_front());
        mfidx = 0;
      end else begin
        mfidx++;
      end
    end
    if (v) begin
      if (full) begin
        if (mdrop < 65535) mdrop++;
      end else begin
        mq.push_back(p);
      end
    end
    @(negedge clk);
    packet_in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    packet_in_valid = 1'b0;
    flit_out_ready = 1'b0;
    mq.delete();
    mfidx = 0;
    mdrop = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", flit_out_valid); end
    n_tests++; if (flit_out_sop !== 1'b0) begin n_fail++; $display("FAIL reset_sop: got %b exp 0", flit_out_sop); end
    n_tests++; if (flit_out_eop !== 1'b0) begin n_fail++; $display("FAIL reset_eop: got %b exp 0", flit_out_eop); end
    n_tests++; if (packet_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", packet_in_ready); end
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d exp 0", fifo_level); end
    n_tests++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d exp 0", drop_count); end
  endtask

  task automatic test_single_packet();
    logic [FW-1:0] exp_f [3];
    exp_f[0] = 32'h0000000A; exp_f[1] = 32'h0000000B; exp_f[2] = 32'h0000000C;
    apply_reset();
    cycle(1'b1, 96'h0000000C_0000000B_0000000A, 1'b1);
    n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level1: got %0d exp 1", fifo_level); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (flit_out_valid !== 1'b1 || flit_out !== exp_f[i] ||
          flit_out_sop !== (i == 0) || flit_out_eop !== (i == 2)) begin
        n_fail++;
        $display("FAIL single_flit%0d: got v=%b d=%h s=%b e=%b exp v=1 d=%h s=%b e=%b",
                 i, flit_out_valid, flit_out, flit_out_sop, flit_out_eop, exp_f[i], i == 0, i == 2);
      end
      cycle(1'b0, '0, 1'b1);
    end
    n_tests++; if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b exp 0", flit_out_valid); end
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_level0: got %0d exp 0", fifo_level); end
  endtask

  task automatic test_overflow();
    logic [PW-1:0] pk [5];
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      pk[i] = rnd_pkt();
      pk[i][7:0] = 8'(i);
      cycle(1'b1, pk[i], 1'b0);
    end
    n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d exp 4", fifo_level); end
    n_tests++; if (packet_in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %b exp 0", packet_in_ready); end
    n_tests++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL ovf_drop: got %0d exp 1", drop_count); end
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (flit_out_valid !== 1'b1 || flit_out !== slice(pk[i/3], i%3) ||
          flit_out_sop !== (i%3 == 0) || flit_out_eop !== (i%3 == 2)) begin
        n_fail++;
        $display("FAIL ovf_flit%0d: got v=%b d=%h s=%b e=%b exp d=%h", i, flit_out_valid,
                 flit_out, flit_out_sop, flit_out_eop, slice(pk[i/3], i%3));
      end
      cycle(1'b0, '0, 1'b1);
    end
    n_tests++; if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b exp 0", flit_out_valid); end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] p;
    apply_reset();
    p = rnd_pkt();
    cycle(1'b1, p, 1'b1);
    n_tests++; if (flit_out !== slice(p, 0) || flit_out_sop !== 1'b1) begin n_fail++; $display("FAIL bp_first: got %h sop %b exp %h sop 1", flit_out, flit_out_sop, slice(p, 0)); end
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (flit_out_valid !== 1'b1 || flit_out !== slice(p, 1) || flit_out_sop !== 1'b0 || flit_out_eop !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h s=%b e=%b exp v=1 d=%h s=0 e=0", i, flit_out_valid,
                 flit_out, flit_out_sop, flit_out_eop, slice(p, 1));
      end
      cycle(1'b0, '0, 1'b0);
    end
    n_tests++; if (flit_out !== slice(p, 1)) begin n_fail++; $display("FAIL bp_resume1: got %h exp %h", flit_out, slice(p, 1)); end
    cycle(1'b0, '0, 1'b1);
    n_tests++; if (flit_out !== slice(p, 2) || flit_out_eop !== 1'b1) begin n_fail++; $display("FAIL bp_resume2: got %h eop %b exp %h eop 1", flit_out, flit_out_eop, slice(p, 2)); end
    cycle(1'b0, '0, 1'b1);
    n_tests++; if (flit_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b exp 0", flit_out_valid); end
  endtask

  task automatic test_full_pop();
    logic [PW-1:0] pk [4];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      pk[i] = rnd_pkt();
      cycle(1'b1, pk[i], 1'b0);
    end
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    n_tests++; if (flit_out_eop !== 1'b1 || fifo_level !== 3'd4) begin n_fail++; $display("FAIL fp_pre: got eop %b level %0d exp eop 1 level 4", flit_out_eop, fifo_level); end
    cycle(1'b1, rnd_pkt(), 1'b1);
    n_tests++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL fp_level: got %0d exp 3", fifo_level); end
    n_tests++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL fp_drop: got %0d exp 1", drop_count); end
    for (int i = 3; i < 12; i++) begin
      n_tests++;
      if (flit_out_valid !== 1'b1 || flit_out !== slice(pk[i/3], i%3)) begin
        n_fail++;
        $display("FAIL fp_flit%0d: got v=%b d=%h exp %h", i, flit_out_valid, flit_out, slice(pk[i/3], i%3));
      end
      cycle(1'b0, '0, 1'b1);
    end
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL fp_empty: got %0d exp 0", fifo_level); end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] p;
    apply_reset();
    cycle(1'b1, rnd_pkt(), 1'b0);
    cycle(1'b1, rnd_pkt(), 1'b0);
    cycle(1'b0, '0, 1'b1);
    flit_out_ready = 1'b0;
    n_tests++; if (flit_out_sop !== 1'b0 || flit_out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_mid: got v=%b sop=%b exp v=1 sop=0", flit_out_valid, flit_out_sop); end
    #2 reset_n = 1'b0;
    mq.delete(); mfidx = 0; mdrop = 0;
    #1;
    n_tests++;
    if (flit_out_valid !== 1'b0 || flit_out_sop !== 1'b0 || flit_out_eop !== 1'b0 ||
        packet_in_ready !== 1'b1 || fifo_level !== 3'd0 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rm_outputs: got v=%b s=%b e=%b rdy=%b lvl=%0d drop=%0d exp 0 0 0 1 0 0",
               flit_out_valid, flit_out_sop, flit_out_eop, packet_in_ready, fifo_level, drop_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    p = rnd_pkt();
    cycle(1'b1, p, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (flit_out_valid !== 1'b1 || flit_out !== slice(p, i) || flit_out_sop !== (i == 0) || flit_out_eop !== (i == 2)) begin
        n_fail++;
        $display("FAIL rm_new%0d: got v=%b d=%h s=%b e=%b exp d=%h", i, flit_out_valid, flit_out,
                 flit_out_sop, flit_out_eop, slice(p, i));
      end
      cycle(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_random_stream();
    int  pushed;
    int  c;
    bit  v;
    apply_reset();
    pushed = 0;
    c = 0;
    while (c < 500 && !(pushed == 10 && mq.size() == 0)) begin
      n_tests++;
      if (flit_out_valid !== (mq.size() > 0) || fifo_level !== 3'(mq.size()) ||
          packet_in_ready !== (mq.size() != D) || drop_count !== 16'(mdrop) ||
          (mq.size() > 0 && (flit_out !== model_flit() || flit_out_sop !== (mfidx == 0) ||
                             flit_out_eop !== (mfidx == F - 1)))) begin
        n_fail++;
        $display("FAIL rnd_c%0d: got v=%b d=%h s=%b e=%b lvl=%0d rdy=%b drop=%0d exp v=%b d=%h fidx=%0d lvl=%0d drop=%0d",
                 c, flit_out_valid, flit_out, flit_out_sop, flit_out_eop, fifo_level, packet_in_ready,
                 drop_count, mq.size() > 0, model_flit(), mfidx, mq.size(), mdrop);
      end
      v = (pushed < 10) && (mq.size() < D) && ($urandom_range(1, 0) == 1);
      cycle(v, rnd_pkt(), 1'($urandom_range(1, 0)));
      if (v) pushed++;
      c++;
    end
    n_tests++; if (pushed != 10 || mq.size() != 0 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL rnd_timeout: got pushed=%0d level=%0d exp 10 and empty", pushed, fifo_level); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_pkt(), 1'b0);
    for (int i = 0; i < 65534; i++) cycle(1'b1, '0, 1'b0);
    n_tests++; if (drop_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe: got %h exp fffe", drop_count); end
    cycle(1'b1, '0, 1'b0);
    n_tests++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff: got %h exp ffff", drop_count); end
    for (int i = 0; i < 5; i++) cycle(1'b1, '0, 1'b0);
    n_tests++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h exp ffff", drop_count); end
    n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL sat_level: got %0d exp 4", fifo_level); end
  endtask

  initial begin
    reset_n         = 1'b0;
    packet_in       = '0;
    packet_in_valid = 1'b0;
    flit_out_ready  = 1'b0;
    mfidx           = 0;
    mdrop           = 0;
    test_reset();
    test_single_packet();
    test_overflow();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_random_stream();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
